// File: rtl/byte_mem_arbiter.sv
// byte_mem_arbiter
//   Arbitrates instruction-fetch (IF) and data-access (MEM) requests onto a
//   byte-wide RAM/IO port. Multi-byte accesses are split into single-byte
//   RAM cycles, and read bytes are reassembled little-endian into 32 bits.
//   MEM wins over IF when both request in the same IDLE cycle.
//
// Ports
//   clk_in, rst_in, rdy_in    : clock, sync active-high reset, run/freeze
//   if_req_i/if_addr_i        : fetch request (always 4 bytes)
//   if_cancel_i               : abort a pending or in-flight fetch
//   if_done_o/if_data_o       : one-cycle completion pulse + fetched word
//   mem_req_i/mem_we_i        : data access request, write enable
//   mem_len_i                 : 1, 2 or 4 bytes (anything else means 4)
//   mem_addr_i/mem_wdata_i    : data address / write data
//   mem_done_o/mem_rdata_o    : one-cycle completion pulse + read data
//   ram_din_i                 : byte returned one cycle after its address
//   ram_dout_o/ram_addr_o     : byte to write / byte address
//   ram_wr_o                  : write strobe
//   busy_o                    : high whenever the FSM is not IDLE
module byte_mem_arbiter #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_cancel_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [2:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              own_if_q, own_if_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        len_q, len_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        iss_q, iss_d;     // addresses issued so far
    logic [2:0]        cap_q, cap_d;     // bytes captured so far
    logic              drv_q, drv_d;     // ram_addr_o carries a live read
    logic              rvld_q, rvld_d;   // ram_din_i holds byte for lane cap_q
    logic [31:0]       lanes_q, lanes_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              wr_q, wr_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              busy_q;

    logic [2:0]        req_len;
    logic [31:0]       lanes_cap;

    always_comb begin
        req_len = 3'd4;
        if (mem_len_i == 3'd1) begin
            req_len = 3'd1;
        end else if (mem_len_i == 3'd2) begin
            req_len = 3'd2;
        end

        state_d     = state_q;
        own_if_d    = own_if_q;
        base_d      = base_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        iss_d       = iss_q;
        cap_d       = cap_q;
        drv_d       = drv_q;
        rvld_d      = rvld_q;
        lanes_d     = lanes_q;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = '0;
        wr_d        = 1'b0;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;

        lanes_cap = lanes_q;
        lanes_cap[{cap_q[1:0], 3'b000} +: 8] = ram_din_i;

        case (state_q)
            S_IDLE: begin
                if (mem_req_i) begin
                    own_if_d   = 1'b0;
                    base_d     = mem_addr_i;
                    len_d      = req_len;
                    wdata_d    = mem_wdata_i;
                    iss_d      = 3'd1;
                    cap_d      = '0;
                    lanes_d    = '0;
                    rvld_d     = 1'b0;
                    ram_addr_d = mem_addr_i;
                    if (mem_we_i) begin
                        state_d    = S_WRITE;
                        wr_d       = 1'b1;
                        ram_dout_d = mem_wdata_i[7:0];
                        drv_d      = 1'b0;
                    end else begin
                        state_d = S_READ;
                        drv_d   = 1'b1;
                    end
                end else if (if_req_i && !if_cancel_i) begin
                    own_if_d   = 1'b1;
                    base_d     = if_addr_i;
                    len_d      = 3'd4;
                    iss_d      = 3'd1;
                    cap_d      = '0;
                    lanes_d    = '0;
                    rvld_d     = 1'b0;
                    drv_d      = 1'b1;
                    ram_addr_d = if_addr_i;
                    state_d    = S_READ;
                end
            end

            S_READ: begin
                if (own_if_q && if_cancel_i) begin
                    state_d    = S_IDLE;
                    ram_addr_d = '0;
                    drv_d      = 1'b0;
                    rvld_d     = 1'b0;
                end else begin
                    // Issue runs one cycle ahead of capture; once all bytes
                    // are issued the address bus parks at 0 so no extra
                    // read of a read-sensitive IO address occurs.
                    rvld_d = drv_q;
                    if (rvld_q) begin
                        lanes_d = lanes_cap;
                        cap_d   = cap_q + 3'd1;
                    end
                    if (iss_q < len_q) begin
                        ram_addr_d = base_q + ADDR_W'(iss_q);
                        iss_d      = iss_q + 3'd1;
                        drv_d      = 1'b1;
                    end else begin
                        ram_addr_d = '0;
                        drv_d      = 1'b0;
                    end
                    if (rvld_q && (cap_q + 3'd1 == len_q)) begin
                        state_d = S_DONE;
                        if (own_if_q) begin
                            if_done_d = 1'b1;
                            if_data_d = lanes_cap;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = lanes_cap;
                        end
                    end
                end
            end

            S_WRITE: begin
                if (iss_q < len_q) begin
                    ram_addr_d = base_q + ADDR_W'(iss_q);
                    ram_dout_d = wdata_q[{iss_q[1:0], 3'b000} +: 8];
                    wr_d       = 1'b1;
                    iss_d      = iss_q + 3'd1;
                end else begin
                    ram_addr_d = '0;
                    state_d    = S_DONE;
                    mem_done_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // rdy_in low freezes every register, including a pending done pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            own_if_q    <= 1'b0;
            base_q      <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            iss_q       <= '0;
            cap_q       <= '0;
            drv_q       <= 1'b0;
            rvld_q      <= 1'b0;
            lanes_q     <= '0;
            ram_addr_q  <= '0;
            ram_dout_q  <= '0;
            wr_q        <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            own_if_q    <= own_if_d;
            base_q      <= base_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            iss_q       <= iss_d;
            cap_q       <= cap_d;
            drv_q       <= drv_d;
            rvld_q      <= rvld_d;
            lanes_q     <= lanes_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
            wr_q        <= wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    // Strobes are masked while frozen; the held registers re-assert them
    // in the first running cycle.
    assign ram_wr_o    = wr_q & rdy_in;
    assign if_done_o   = if_done_q & rdy_in;
    assign mem_done_o  = mem_done_q & rdy_in;
    assign ram_addr_o  = ram_addr_q;
    assign ram_dout_o  = ram_dout_q;
    assign if_data_o   = if_data_q;
    assign mem_rdata_o = mem_rdata_q;
    assign busy_o      = busy_q;

endmodule
